toggle_monitor: RTL and testbench
=================================

# toggle_monitor

Passive observer for a single-bit stream that must invert on every `clk` edge, such as a `a <= ~a` flop on the system clock. Samples the stream each rising edge, acquires lock after a run of good toggles, counts samples and toggle failures, and posts one timestamped event per failure through a valid/ready port. Sits beside the driving flop in scheduling and region testbenches as its self-checking reader.

## Interface
- `CNT_W`, 16: width of sample counter, error counter and event payload (≥ 4).
- `LOCK_LEN`, 4: consecutive good toggles required to enter/re-enter LOCKED (1..2^CNT_W−1).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `en`  in  1  sample enable; when low, nothing updates except the event handshake.
- `clr`  in  1  synchronous clear of counters, state and event slot.
- `a`  in  1  observed stream.
- `locked`  out  1  high in LOCKED.
- `fault`  out  1  high in FAULT.
- `sample_cnt`  out  CNT_W  enabled samples taken, saturating.
- `err_cnt`  out  CNT_W  toggle failures detected, saturating.
- `evt_valid`  out  1  event slot occupied.
- `evt_ready`  in  1  consumer accepts event.
- `evt_data`  out  CNT_W  `sample_cnt` value at the failing sample.
- `evt_ovf`  out  1  sticky: an event was dropped because the slot was full.

## Operation
- Priming: first enabled sample after `rst`, `clr` or an `en` low period only loads `a_prev`; no compare, `sample_cnt` still increments.
- Compare: good = `a != a_prev`; bad = `a == a_prev`. `a_prev` updates on every enabled sample.
- `run` counter (width to hold `LOCK_LEN`): +1 on good, 0 on bad.
- States:
  - HUNT (reset): bad → stay, run=0, no error counted. Good with run+1 == `LOCK_LEN` → LOCKED.
  - LOCKED: bad → FAULT, `err_cnt`+1, post event. Good → stay.
  - FAULT: bad → stay, `err_cnt`+1, post event, run=0. Good with run+1 == `LOCK_LEN` → LOCKED.
- Event posting: if slot empty, or occupied and accepted this cycle, load `evt_data` = pre-increment `sample_cnt`, `evt_valid`=1. Otherwise drop, set `evt_ovf`.
- Counters saturate at all ones; saturated `sample_cnt` is still used as timestamp.
- Priority: `rst` > `clr` > normal operation. `clr` = reset values except `clr` is ignored while `rst` is high.

## Timing
- Reset/clear values: `locked`=0, `fault`=0, `sample_cnt`=0, `err_cnt`=0, `evt_valid`=0, `evt_data`=0, `evt_ovf`=0, state HUNT, primed=0.
- All outputs are registered. A bad sample at edge N is visible on `fault`, `err_cnt` and `evt_valid` after edge N. Lock is visible after the `LOCK_LEN`-th good compare.
- Handshake: transfer when `evt_valid && evt_ready` at an edge. `evt_valid`/`evt_data` are stable until transfer. Transfer plus new event on the same edge leaves `evt_valid`=1 with the new data and no overflow. `evt_ready` with `evt_valid`=0 has no effect.
- Handshake runs regardless of `en`. `clr` discards a pending event.
- `en` low for one or more cycles drops priming. The next enabled sample re-primes and is never flagged, even if `a` held.
- `rst` mid-FAULT with a pending event: all cleared on that edge, event lost, no overflow.

## Configuration
- `TOGGLE_MONITOR_LOG_EN` defined: simulation-only `$strobe` in the postponed region on every state change and every posted or dropped event, printing `$time`, state, `a`, `err_cnt`. Hardware behaviour is identical.
- Undefined: no display tasks compiled. Block is fully synthesizable.

## Test plan
- Reset, then `a` toggles every edge, `en`=1, `LOCK_LEN`=4 → primed at sample 1, `locked`=1 after sample 5, `err_cnt`=0, `sample_cnt`=20 after 20 samples.
- Locked, `a` held for one edge at sample 10 → `fault`=1, `err_cnt`=1, `evt_valid`=1, `evt_data`=9. Four toggles later `locked`=1.
- `evt_ready`=0, three bad samples at 10, 11, 12 → `evt_data`=9, `err_cnt`=3, `evt_ovf`=1. `evt_ready`=1 at the next bad sample → `evt_valid` stays 1 with the new timestamp, no additional overflow.
- `en` low 3 cycles, `a` frozen, `en` high → no error, re-prime, `err_cnt` unchanged.
- `CNT_W`=4, 20 toggles → `sample_cnt` saturates at 15. A bad sample then → `evt_data`=15.
- `clr` and `rst` asserted mid-FAULT with a pending event → all outputs at reset values next cycle. `clr` alone behaves the same.

Source files
------------

// File: rtl/toggle_monitor.sv
// Passive checker for a stream that must invert every clock: locks after LOCK_LEN good
// toggles, counts samples/failures, posts one timestamped event per failure (valid/ready).
// Optional TOGGLE_MONITOR_LOG_EN: simulation-only $strobe trace of state changes and events.
module toggle_monitor #(
  parameter int CNT_W    = 16,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_data,
  output logic             evt_ovf
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W:0] LOCK_V = (RUN_W + 1)'(LOCK_LEN);

  typedef enum logic [1:0] {HUNT, LOCKED, FAULT} state_e;

  state_e             state_q, state_d;
  logic               primed_q, primed_d;
  logic               a_prev_q, a_prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [RUN_W:0]     run_inc;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               evt_valid_q, evt_valid_d;
  logic [CNT_W-1:0]   evt_data_q, evt_data_d;
  logic               evt_ovf_q, evt_ovf_d;
  logic               good, bad, post, accept;

  assign run_inc = {1'b0, run_q} + 1'b1;
  assign good    = en && primed_q && (a != a_prev_q);
  assign bad     = en && primed_q && (a == a_prev_q);
  // Misses while still hunting are not failures; only a lost lock is reported.
  assign post    = bad && (state_q != HUNT);
  assign accept  = evt_valid_q && evt_ready;

  always_ff @(posedge clk) begin
    if (rst || clr) state_q <= HUNT;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT, FAULT: begin
        if (bad && state_q == LOCKED) state_d = FAULT;
        if (good && run_inc == LOCK_V) state_d = LOCKED;
      end
      LOCKED:  if (bad) state_d = FAULT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    locked = (state_q == LOCKED);
    fault  = (state_q == FAULT);
  end

  always_comb begin
    primed_d     = primed_q;
    a_prev_d     = a_prev_q;
    run_d        = run_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    evt_valid_d  = evt_valid_q;
    evt_data_d   = evt_data_q;
    evt_ovf_d    = evt_ovf_q;
    if (en) begin
      primed_d = 1'b1;
      a_prev_d = a;
      if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + 1'b1;
    end else begin
      primed_d = 1'b0;
    end
    // run saturates at LOCK_LEN so it never wraps while LOCKED
    if (good && run_inc <= LOCK_V) run_d = run_inc[RUN_W-1:0];
    if (bad) run_d = '0;
    if (post && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    if (post) begin
      if (!evt_valid_q || accept) begin
        evt_valid_d = 1'b1;
        evt_data_d  = sample_cnt_q;
      end else begin
        evt_ovf_d = 1'b1;
      end
    end else if (accept) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      primed_q     <= 1'b0;
      a_prev_q     <= 1'b0;
      run_q        <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      evt_valid_q  <= 1'b0;
      evt_data_q   <= '0;
      evt_ovf_q    <= 1'b0;
    end else begin
      primed_q     <= primed_d;
      a_prev_q     <= a_prev_d;
      run_q        <= run_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      evt_valid_q  <= evt_valid_d;
      evt_data_q   <= evt_data_d;
      evt_ovf_q    <= evt_ovf_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign evt_valid  = evt_valid_q;
  assign evt_data   = evt_data_q;
  assign evt_ovf    = evt_ovf_q;

`ifdef TOGGLE_MONITOR_LOG_EN
  // $strobe prints post-update values, so the line shows the state after this edge.
  always @(posedge clk) begin
    if (!rst && !clr && (state_d != state_q || post))
      $strobe("[toggle_monitor] t=%0t state=%s a=%b err_cnt=%0d", $time, state_q.name(), a, err_cnt_q);
  end
`endif

endmodule

// File: tb/tb_toggle_monitor.sv
// Random + directed bench for toggle_monitor: two instances (16-bit and 4-bit counters)
// share stimulus and are checked every cycle against a behavioural model.
module tb_toggle_monitor;
  localparam int LOCK_LEN = 4;
  localparam int HU = 0, LK = 1, FT = 2;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, clr = 1'b0, a = 1'b0, evt_ready = 1'b0;
  logic        lk0, ft0, v0, ov0, lk1, ft1, v1, ov1;
  logic [15:0] sc0, ec0, d0;
  logic [3:0]  sc1, ec1, d1;

  int n_tests = 0, n_fail = 0;
  int maxv[2] = '{65535, 15};
  int m_st[2], m_samp[2], m_err[2], m_run[2], m_data[2];
  bit m_primed[2], m_prev[2], m_vld[2], m_ovf[2];

  toggle_monitor #(.CNT_W(16), .LOCK_LEN(LOCK_LEN)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .locked(lk0), .fault(ft0),
    .sample_cnt(sc0), .err_cnt(ec0), .evt_valid(v0), .evt_ready(evt_ready),
    .evt_data(d0), .evt_ovf(ov0));
  toggle_monitor #(.CNT_W(4), .LOCK_LEN(LOCK_LEN)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .locked(lk1), .fault(ft1),
    .sample_cnt(sc1), .err_cnt(ec1), .evt_valid(v1), .evt_ready(evt_ready),
    .evt_data(d1), .evt_ovf(ov1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the monitor as described behaviourally.
  task automatic model(input int k);
    bit acc, post;
    int stamp;
    if (rst || clr) begin
      m_st[k] = HU; m_samp[k] = 0; m_err[k] = 0; m_run[k] = 0; m_data[k] = 0;
      m_primed[k] = 0; m_prev[k] = 0; m_vld[k] = 0; m_ovf[k] = 0;
      return;
    end
    acc = m_vld[k] && evt_ready;
    post = 0;
    stamp = m_samp[k];
    if (en) begin
      if (m_primed[k]) begin
        if (a != m_prev[k]) begin
          m_run[k]++;
          if (m_st[k] != LK && m_run[k] == LOCK_LEN) m_st[k] = LK;
        end else begin
          m_run[k] = 0;
          if (m_st[k] != HU) begin
            m_st[k] = FT;
            if (m_err[k] < maxv[k]) m_err[k]++;
            post = 1;
          end
        end
      end
      m_primed[k] = 1;
      m_prev[k] = a;
      if (m_samp[k] < maxv[k]) m_samp[k]++;
    end else begin
      m_primed[k] = 0;
    end
    if (post) begin
      if (!m_vld[k] || acc) begin m_vld[k] = 1; m_data[k] = stamp; end
      else m_ovf[k] = 1;
    end else if (acc) begin
      m_vld[k] = 0;
    end
  endtask

  task automatic check_dut(input int k, input logic lk, input logic ft, input logic [31:0] sc,
                           input logic [31:0] ec, input logic v, input logic [31:0] d, input logic ov);
    chk($sformatf("u%0d.locked", k), 32'(lk), 32'(m_st[k] == LK));
    chk($sformatf("u%0d.fault", k), 32'(ft), 32'(m_st[k] == FT));
    chk($sformatf("u%0d.sample_cnt", k), sc, 32'(m_samp[k]));
    chk($sformatf("u%0d.err_cnt", k), ec, 32'(m_err[k]));
    chk($sformatf("u%0d.evt_valid", k), 32'(v), 32'(m_vld[k]));
    if (m_vld[k] || k == 0) chk($sformatf("u%0d.evt_data", k), d, 32'(m_data[k]));
    chk($sformatf("u%0d.evt_ovf", k), 32'(ov), 32'(m_ovf[k]));
  endtask

  task automatic step(input bit tog, input bit e, input bit c, input bit r, input bit rdy);
    en = e; clr = c; rst = r; evt_ready = rdy;
    if (tog) a = ~a;
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check_dut(0, lk0, ft0, 32'(sc0), 32'(ec0), v0, 32'(d0), ov0);
    check_dut(1, lk1, ft1, 32'(sc1), 32'(ec1), v1, 32'(d1), ov1);
  endtask

  initial begin
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("rst.sample_cnt", 32'(sc0), 0);
    chk("rst.locked", 32'(lk0), 0);

    // 20 clean toggles, then one held sample
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 0, 0, 0);
      if (i == 4) chk("lock.not_yet", 32'(lk0), 0);
      if (i == 5) chk("lock.after5", 32'(lk0), 1);
    end
    chk("cnt20.u0", 32'(sc0), 20);
    chk("cnt20.u1_sat", 32'(sc1), 15);
    chk("cnt20.err", 32'(ec0), 0);
    step(0, 1, 0, 0, 0);
    chk("sat.u1_evt_data", 32'(d1), 15);
    chk("sat.u0_evt_data", 32'(d0), 20);

    // fault at sample 10, overflow while slot full, replace on accept
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= 9; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("f10.fault", 32'(ft0), 1);
    chk("f10.err", 32'(ec0), 1);
    chk("f10.evt_data", 32'(d0), 9);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("ovf.err", 32'(ec0), 3);
    chk("ovf.flag", 32'(ov0), 1);
    chk("ovf.data_held", 32'(d0), 9);
    step(0, 1, 0, 0, 1);
    chk("repl.valid", 32'(v0), 1);
    chk("repl.data", 32'(d0), 12);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
    chk("relock", 32'(lk0), 1);

    // en low with frozen stream: re-prime, no error
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("reprime.err", 32'(ec0), 4);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);

    // clr+rst, then clr alone, while FAULT with a pending event
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    chk("clrrst.valid", 32'(v0), 0);
    chk("clrrst.ovf", 32'(ov0), 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("clr.fault", 32'(ft0), 0);
    chk("clr.err", 32'(ec0), 0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
